// File: rtl/lua_pkg.sv
// -----------------------------------------------------------------------------
// lua_pkg
// Shared definitions for the linear-address-unit arbiter.
//   lua_state_e : arbiter FSM states
//   id_width()  : requester-id width, never narrower than one bit
//   addr_width(): address width produced by the Y*BLOCK_SIZE+X unit
// -----------------------------------------------------------------------------
package lua_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lua_state_e;

   // max(1, clog2(n)) so a single requester still gets a legal id port
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Product of two DATA_WIDTH operands plus an addend fits in twice the width
   function automatic int addr_width(input int dw);
      return 2 * dw;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: first set request bit starting at last+1,
// wrapping around. Never selects a requester whose request bit is low.
//   req   : request vector
//   last  : index of the previously granted requester
//   grant : one-hot winner (all zero when nothing requests)
//   idx   : binary index of the winner (0 when nothing requests)
//   any   : at least one request bit set
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   always_comb begin
      int cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      // k = 1..NUM_REQ visits last+1 first and last itself at the very end
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/lua_arbiter.sv
// -----------------------------------------------------------------------------
// lua_arbiter
// Round-robin scheduler sharing one sequential linear-address unit
// (Address = Y*BLOCK_SIZE + X, Start/Ready handshake) among NUM_REQ clients.
// One request in flight at a time, no queueing.
//   Clk, Rst_n          : clock, async active-low reset
//   ReqValid/ReqX/ReqY  : per-requester request, packed slices (slice i = req i)
//   ReqReady            : one-hot acceptance strobe (combinational, IDLE only)
//   RespValid/RespId/RespAddress/RespReady : response channel
//   UnitX/UnitY/UnitStart : operands and start strobe to the address unit
//   UnitReady/UnitAddress : unit idle/result-valid flag and result
// -----------------------------------------------------------------------------
module lua_arbiter
   import lua_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = id_width(NUM_REQ)
) (
   input  logic                            Clk,
   input  logic                            Rst_n,
   input  logic [NUM_REQ-1:0]              ReqValid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   ReqX,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   ReqY,
   output logic [NUM_REQ-1:0]              ReqReady,
   output logic                            RespValid,
   output logic [ID_W-1:0]                 RespId,
   output logic [2*DATA_WIDTH-1:0]         RespAddress,
   input  logic                            RespReady,
   output logic [DATA_WIDTH-1:0]           UnitX,
   output logic [DATA_WIDTH-1:0]           UnitY,
   output logic                            UnitStart,
   input  logic                            UnitReady,
   input  logic [2*DATA_WIDTH-1:0]         UnitAddress
);

   localparam int AW = addr_width(DATA_WIDTH);

   lua_state_e state_q, state_d;

   logic [ID_W-1:0]                       last_q;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_x_a, req_y_a;
   logic [NUM_REQ-1:0]                    pick_grant;
   logic [ID_W-1:0]                       pick_idx;
   logic                                  pick_any;
   logic                                  accept;
   logic                                  done;
   logic [AW-1:0]                         unit_addr;

   assign req_x_a   = ReqX;
   assign req_y_a   = ReqY;
   assign unit_addr = UnitAddress;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req   (ReqValid),
      .last  (last_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // A low UnitReady in IDLE means the unit is still finishing work that was
   // abandoned by a reset; granting then would collide with it.
   assign accept = (state_q == IDLE) && UnitReady && pick_any;

   // WAIT is entered only after the unit has sampled Start, so the Ready
   // level seen during ISSUE is never mistaken for completion.
   assign done   = (state_q == WAIT) && UnitReady;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (accept)    state_d = ISSUE;
         ISSUE:                state_d = WAIT;
         WAIT:  if (UnitReady) state_d = RESP;
         RESP:  if (RespReady) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic
   // ---------------------------------------------------------------------
   always_comb begin
      ReqReady  = '0;
      UnitStart = 1'b0;
      RespValid = 1'b0;
      unique case (state_q)
         IDLE:  if (UnitReady) ReqReady = pick_grant;
         ISSUE: UnitStart = 1'b1;
         WAIT:  ;
         RESP:  RespValid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Operand, id and rotation pointer captured at the accept edge; the
   // operands feed the unit directly and hold until the next accept.
   // Last resets to NUM_REQ-1 so requester 0 is searched first.
   // ---------------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         last_q <= ID_W'(NUM_REQ - 1);
         UnitX  <= '0;
         UnitY  <= '0;
         RespId <= '0;
      end else if (accept) begin
         last_q <= pick_idx;
         UnitX  <= req_x_a[pick_idx];
         UnitY  <= req_y_a[pick_idx];
         RespId <= pick_idx;
      end
   end

   // Result is captured once on completion and held through RESP
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)    RespAddress <= '0;
      else if (done) RespAddress <= unit_addr;
   end

endmodule

// File: tb/tb_lua_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lua_arbiter
// Directed bench for lua_arbiter with a behavioural address unit
// (Y*bs + X, Start sampled when idle, DATA_WIDTH busy cycles after sampling).
// Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
// -----------------------------------------------------------------------------
module tb_lua_arbiter;

   localparam int DW = 16;
   localparam int NR = 4;
   localparam int IW = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NR-1:0]        req_valid = '0;
   logic [NR-1:0][DW-1:0] rx = '0, ry = '0;
   logic [NR-1:0]        req_ready;
   logic                 resp_valid;
   logic [IW-1:0]        resp_id;
   logic [2*DW-1:0]      resp_address;
   logic                 resp_ready = 1'b1;
   logic [DW-1:0]        unit_x, unit_y;
   logic                 unit_start;
   logic                 unit_ready;
   logic [2*DW-1:0]      unit_address;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   lua_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .Clk         (clk),
      .Rst_n       (rst_n),
      .ReqValid    (req_valid),
      .ReqX        (rx),
      .ReqY        (ry),
      .ReqReady    (req_ready),
      .RespValid   (resp_valid),
      .RespId      (resp_id),
      .RespAddress (resp_address),
      .RespReady   (resp_ready),
      .UnitX       (unit_x),
      .UnitY       (unit_y),
      .UnitStart   (unit_start),
      .UnitReady   (unit_ready),
      .UnitAddress (unit_address)
   );

   // Behavioural address unit; not reset by Rst_n
   logic [4:0]  u_cnt = '0;
   logic [31:0] u_res = '0;
   logic [31:0] bs = 32'd64;
   logic        busy_hold = 1'b0;

   always @(posedge clk) begin
      if (u_cnt != 0) u_cnt <= u_cnt - 5'd1;
      else if (unit_start) begin
         u_cnt <= 5'd16;
         u_res <= 32'(64'(unit_y) * 64'(bs) + 64'(unit_x));
      end
   end
   assign unit_ready   = (u_cnt == 0) && !busy_hold;
   assign unit_address = (u_cnt == 0) ? u_res : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after a posedge; samples successive negedges
   task automatic wait_grant(input int maxc);
      int n = 0;
      do begin @(negedge clk); n++; end while (req_ready == 0 && n < maxc);
      check("grant_seen", 64'(req_ready != 0), 64'd1);
   endtask

   task automatic wait_resp(input int maxc, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid && n < maxc);
      check("resp_seen", 64'(resp_valid), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // ---------------- reset values
      @(negedge clk);
      check("rst_reqready",  64'(req_ready),    64'd0);
      check("rst_respvalid", 64'(resp_valid),   64'd0);
      check("rst_respid",    64'(resp_id),      64'd0);
      check("rst_respaddr",  64'(resp_address), 64'd0);
      check("rst_unitstart", 64'(unit_start),   64'd0);
      check("rst_unitx",     64'(unit_x),       64'd0);
      check("rst_unity",     64'(unit_y),       64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // ---------------- single request: req 2, X=5 Y=3, bs=64 -> 197
      @(posedge clk); #1;
      rx[2] = 16'd5; ry[2] = 16'd3; req_valid = 4'b0100;
      wait_grant(20);
      check("t1_grant", 64'(req_ready), 64'h4);
      @(posedge clk); #1 req_valid = '0;         // accept edge T
      @(negedge clk);                            // ISSUE cycle T+1
      check("t1_pulse",  64'(req_ready),  64'd0);
      check("t1_start",  64'(unit_start), 64'd1);
      check("t1_unitx",  64'(unit_x),     64'd5);
      check("t1_unity",  64'(unit_y),     64'd3);
      @(negedge clk);                            // WAIT cycle T+2
      check("t1_start1", 64'(unit_start), 64'd0);
      wait_resp(40, n);                          // first negedge is cycle T+3
      check("t1_latency", 64'(n + 2), 64'd19);
      check("t1_id",   64'(resp_id),      64'd2);
      check("t1_addr", 64'(resp_address), 64'd197);
      @(negedge clk);
      check("t1_respdrop", 64'(resp_valid), 64'd0);

      // ---------------- rotation with all four valid, from reset
      rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < NR; i++) begin
         rx[i] = 16'(10 + i); ry[i] = 16'(20 + i);
      end
      req_valid = 4'b1111;
      for (int r = 0; r < 5; r++) begin
         wait_resp(40, n);
         check("rr_id",   64'(resp_id), 64'(r % NR));
         check("rr_addr", 64'(resp_address), 64'((20 + r % NR) * 64 + 10 + r % NR));
         if (r == 4) req_valid = '0;
         @(posedge clk); #1;
      end

      // ---------------- response backpressure: req 3 X=7 Y=9 -> 583
      rx[3] = 16'd7; ry[3] = 16'd9; rx[0] = 16'd1; ry[0] = 16'd2;
      resp_ready = 1'b0; req_valid = 4'b1000;
      wait_grant(20);
      check("t4_grant", 64'(req_ready), 64'h8);
      @(posedge clk); #1 req_valid = 4'b0001;    // another client waits
      wait_resp(40, n);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         check("hold_valid", 64'(resp_valid),   64'd1);
         check("hold_id",    64'(resp_id),      64'd3);
         check("hold_addr",  64'(resp_address), 64'd583);
         check("hold_noreq", 64'(req_ready),    64'd0);
         check("hold_nost",  64'(unit_start),   64'd0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk);
      check("hold_still", 64'(resp_valid), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_next_grant", 64'(req_ready), 64'h1);
      @(posedge clk); #1 req_valid = '0;
      wait_resp(40, n);
      check("t4_id0",   64'(resp_id),      64'd0);
      check("t4_addr0", 64'(resp_address), 64'd129);
      @(posedge clk); #1;

      // ---------------- reset in WAIT, then req 1 X=6 Y=2 -> 134
      rx[2] = 16'd4; ry[2] = 16'd4; req_valid = 4'b0100;
      wait_grant(20);
      @(posedge clk); #1 req_valid = '0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mr_reqready",  64'(req_ready),    64'd0);
      check("mr_respvalid", 64'(resp_valid),   64'd0);
      check("mr_respid",    64'(resp_id),      64'd0);
      check("mr_respaddr",  64'(resp_address), 64'd0);
      check("mr_unitstart", 64'(unit_start),   64'd0);
      check("mr_unitx",     64'(unit_x),       64'd0);
      check("mr_unity",     64'(unit_y),       64'd0);
      rx[1] = 16'd6; ry[1] = 16'd2; req_valid = 4'b0010;
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      n = 0;
      while (!unit_ready && n < 40) begin
         check("mr_busy_noreq",   64'(req_ready),  64'd0);
         check("mr_busy_nostart", 64'(unit_start), 64'd0);
         n++;
         @(negedge clk);
      end
      check("mr_busy_seen", 64'(n > 0), 64'd1);
      check("mr_grant1",    64'(req_ready), 64'h2);
      @(posedge clk); #1 req_valid = '0;
      wait_resp(40, n);
      check("mr_id",   64'(resp_id),      64'd1);
      check("mr_addr", 64'(resp_address), 64'd134);
      @(posedge clk); #1;

      // ---------------- max operands, bs=65535 -> 0xFFFF0000
      bs = 32'd65535;
      rx[0] = 16'hFFFF; ry[0] = 16'hFFFF; req_valid = 4'b0001;
      wait_grant(20);
      check("max_grant", 64'(req_ready), 64'h1);
      @(posedge clk); #1 req_valid = '0;
      wait_resp(40, n);
      check("max_id",   64'(resp_id),      64'd0);
      check("max_addr", 64'(resp_address), 64'hFFFF0000);
      @(posedge clk); #1;

      // ---------------- request pulse while unit busy: no grant
      busy_hold = 1'b1;
      @(posedge clk); #1 req_valid = 4'b0001;
      @(negedge clk);
      check("busy_noreq", 64'(req_ready), 64'd0);
      @(posedge clk); #1 req_valid = '0;
      @(negedge clk);
      check("busy_nostart", 64'(unit_start), 64'd0);
      @(posedge clk); #1 busy_hold = 1'b0;
      @(negedge clk);
      check("busy_nostart2", 64'(unit_start), 64'd0);
      check("busy_noreq2",   64'(req_ready),  64'd0);
      @(negedge clk);
      check("busy_nostart3", 64'(unit_start), 64'd0);
      check("busy_noresp",   64'(resp_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
